csa_pipe: RTL and testbench

- Parametrised, pipelined carry-skip adder/subtractor. Successor of the team's fixed 4-bit carry-skip adder.
- Operands split into BLOCK-bit skip blocks. Each block resolves in its own pipeline stage; the block carry-out is registered into the next stage.
- Valid/ready handshake on input and output. Sits between operand registers and the result bus in datapath units.

---
 rtl/csa_pipe.sv | 152 +++++++++++++++
 tb/tb_csa_pipe.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/csa_pipe.sv
// Pipelined carry-skip adder/subtractor: one BLOCK-bit skip block per stage, valid/ready on both sides.
// Optional macro CSA_SKIP_CNT_EN adds skip_cnt, a saturating count of retired results that used a skip path.
module csa_pipe #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned BLOCK = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             c_in,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] s,
  output logic             c_out,
  output logic             ovf
`ifdef CSA_SKIP_CNT_EN
  ,
  output logic [15:0]      skip_cnt
`endif
);

  localparam int unsigned NUM_BLK = WIDTH / BLOCK;
  localparam int unsigned LAST    = NUM_BLK - 1;

  // Operands travel whole; only the slice of the stage's own block is consumed.
  typedef struct packed {
    logic             vld;
    logic [WIDTH-1:0] opa;
    logic [WIDTH-1:0] opb;
    logic [WIDTH-1:0] sum;
    logic             cy;
    logic             ov;
  } stage_t;

  stage_t stg_q [NUM_BLK];
  stage_t stg_d [NUM_BLK];
  stage_t in_stg;
  logic   advance_c;

  // Resolve block k of a stage: ripple the sum bits, pick the block carry through the skip mux.
  function automatic stage_t blk_step(input stage_t src, input int unsigned k);
    stage_t           dst;
    logic [BLOCK-1:0] pa;
    logic [BLOCK-1:0] pb;
    logic [BLOCK-1:0] pp;
    logic             rc;
    logic             cmsb;
    dst  = src;
    pa   = src.opa[k*BLOCK +: BLOCK];
    pb   = src.opb[k*BLOCK +: BLOCK];
    pp   = pa ^ pb;
    rc   = src.cy;
    cmsb = 1'b0;
    for (int unsigned j = 0; j < BLOCK; j++) begin
      dst.sum[k*BLOCK + j] = pp[j] ^ rc;
      cmsb = rc;
      rc   = (pa[j] & pb[j]) | (rc & pp[j]);
    end
    dst.cy = (&pp) ? src.cy : rc;
    dst.ov = cmsb ^ dst.cy;
    return dst;
  endfunction

  assign advance_c = !stg_q[LAST].vld || out_ready;
  assign in_ready  = advance_c;

  // Bubbles enter as all-zero so no operand is sampled without a transfer.
  always_comb begin
    in_stg = '0;
    if (in_valid) begin
      in_stg.vld = 1'b1;
      in_stg.opa = a;
      in_stg.opb = sub ? ~b : b;
      in_stg.cy  = sub | c_in;
    end
  end

  always_comb begin
    for (int unsigned k = 0; k < NUM_BLK; k++) begin
      stg_d[k] = stg_q[k];
    end
    if (advance_c) begin
      stg_d[0] = blk_step(in_stg, 0);
      for (int unsigned k = 1; k < NUM_BLK; k++) begin
        stg_d[k] = blk_step(stg_q[k-1], k);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned k = 0; k < NUM_BLK; k++) begin
        stg_q[k] <= '0;
      end
    end else begin
      for (int unsigned k = 0; k < NUM_BLK; k++) begin
        stg_q[k] <= stg_d[k];
      end
    end
  end

  assign out_valid = stg_q[LAST].vld;
  assign s         = stg_q[LAST].sum;
  assign c_out     = stg_q[LAST].cy;
  assign ovf       = stg_q[LAST].ov;

`ifdef CSA_SKIP_CNT_EN
  logic [NUM_BLK-1:0] skp_q;
  logic [NUM_BLK-1:0] skp_d;
  logic [15:0]        cnt_q;
  logic [15:0]        cnt_d;

  function automatic logic blk_all_p(input logic [WIDTH-1:0] pa, input logic [WIDTH-1:0] pb,
                                     input int unsigned k);
    logic [WIDTH-1:0] pp;
    pp = pa ^ pb;
    return &pp[k*BLOCK +: BLOCK];
  endfunction

  // The skip flag is sticky along the pipe and counted only when the result retires.
  always_comb begin
    skp_d = skp_q;
    cnt_d = cnt_q;
    if (advance_c) begin
      skp_d[0] = in_stg.vld & blk_all_p(in_stg.opa, in_stg.opb, 0);
      for (int unsigned k = 1; k < NUM_BLK; k++) begin
        skp_d[k] = skp_q[k-1] | blk_all_p(stg_q[k-1].opa, stg_q[k-1].opb, k);
      end
    end
    if (out_valid && out_ready && skp_q[LAST] && (cnt_q != 16'hFFFF)) begin
      cnt_d = cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      skp_q <= '0;
      cnt_q <= '0;
    end else begin
      skp_q <= skp_d;
      cnt_q <= cnt_d;
    end
  end

  assign skip_cnt = cnt_q;
`endif

endmodule

// File: tb/tb_csa_pipe.sv
// Randomised and directed bench for csa_pipe (WIDTH=16, BLOCK=4) against an arithmetic reference model.
module tb_csa_pipe;

  localparam int unsigned W = 16;
  localparam int unsigned LAT = 4;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         c_in;
  logic         sub;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] s;
  logic         c_out;
  logic         ovf;
`ifdef CSA_SKIP_CNT_EN
  logic [15:0]  skip_cnt;
  logic [15:0]  exp_cnt;
`endif

  typedef struct packed {
    logic [W-1:0] s;
    logic         c;
    logic         v;
    logic         k;
  } exp_t;

  exp_t sb[$];
  int   n_chk = 0;
  int   n_err = 0;

  csa_pipe #(.WIDTH(16), .BLOCK(4)) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .a        (a),
    .b        (b),
    .c_in     (c_in),
    .sub      (sub),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .s        (s),
    .c_out    (c_out),
    .ovf      (ovf)
`ifdef CSA_SKIP_CNT_EN
    ,
    .skip_cnt (skip_cnt)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference: plain wide addition; signed overflow from operand/result signs.
  function automatic exp_t model(input logic [W-1:0] xa, input logic [W-1:0] xb,
                                 input logic ci, input logic sb_op);
    exp_t         e;
    logic [W-1:0] be;
    logic [W:0]   t;
    logic [W-1:0] p;
    be  = sb_op ? ~xb : xb;
    t   = {1'b0, xa} + {1'b0, be} + {{W{1'b0}}, (sb_op | ci)};
    e.s = t[W-1:0];
    e.c = t[W];
    e.v = (xa[W-1] == be[W-1]) && (t[W-1] != xa[W-1]);
    p   = xa ^ be;
    e.k = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (p[i*4 +: 4] == 4'hF) e.k = 1'b1;
    end
    return e;
  endfunction

  // Scoreboard: compare the head result whenever out_valid, retire it on transfer.
  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      sb.delete();
`ifdef CSA_SKIP_CNT_EN
      exp_cnt = 16'd0;
`endif
    end else begin
`ifdef CSA_SKIP_CNT_EN
      chk("skip_cnt", 32'(skip_cnt), 32'(exp_cnt));
`endif
      if (out_valid) begin
        if (sb.size() == 0) begin
          chk("stale_out_valid", 32'(out_valid), 32'd0);
        end else begin
          e = sb[0];
          chk("s", 32'(s), 32'(e.s));
          chk("c_out", 32'(c_out), 32'(e.c));
          chk("ovf", 32'(ovf), 32'(e.v));
          if (out_ready) begin
            void'(sb.pop_front());
`ifdef CSA_SKIP_CNT_EN
            if (e.k && exp_cnt != 16'hFFFF) exp_cnt = exp_cnt + 16'd1;
`endif
          end
        end
      end
      if (in_valid && in_ready) sb.push_back(model(a, b, c_in, sub));
    end
  end

  // Single operand into an idle pipe; checks exact latency, one-cycle valid and constant results.
  task automatic run_one(input logic [W-1:0] ta, input logic [W-1:0] tb_op, input logic ci,
                         input logic so, input logic [W-1:0] es, input logic ec, input logic ev);
    a = ta; b = tb_op; c_in = ci; sub = so; in_valid = 1'b1; out_ready = 1'b1;
    @(negedge clk);
    chk("idle_in_ready", 32'(in_ready), 32'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    a = 16'hDEAD; b = 16'hBEEF;
    for (int i = 0; i <= int'(LAT); i++) begin
      @(negedge clk);
      chk($sformatf("latency_valid_%0d", i), 32'(out_valid), (i == int'(LAT) - 1) ? 32'd1 : 32'd0);
      if (i == int'(LAT) - 1) begin
        chk("dir_s", 32'(s), 32'(es));
        chk("dir_c_out", 32'(c_out), 32'(ec));
        chk("dir_ovf", 32'(ovf), 32'(ev));
      end
    end
    @(posedge clk); #1;
  endtask

  initial begin
    int  sent;
    logic xfer;
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    a = '0; b = '0; c_in = 1'b0; sub = 1'b0;
    #12;
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_s", 32'(s), 32'd0);
    chk("rst_c_out", 32'(c_out), 32'd0);
    chk("rst_ovf", 32'(ovf), 32'd0);
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;
    chk("rel_in_ready", 32'(in_ready), 32'd1);

    run_one(16'h1234, 16'h1111, 1'b0, 1'b0, 16'h2345, 1'b0, 1'b0);
    run_one(16'hFFFF, 16'h0000, 1'b1, 1'b0, 16'h0000, 1'b1, 1'b0);
`ifdef CSA_SKIP_CNT_EN
    chk("skip_cnt_after_chain", 32'(skip_cnt), 32'd1);
`endif
    run_one(16'h0005, 16'h0007, 1'b0, 1'b1, 16'hFFFE, 1'b0, 1'b0);
    run_one(16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1);
    run_one(16'h0005, 16'h0007, 1'b1, 1'b1, 16'hFFFE, 1'b0, 1'b0);
    run_one(16'h8000, 16'h0001, 1'b1, 1'b1, 16'h7FFF, 1'b1, 1'b1);
    run_one(16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1);

    // Back-to-back stream with a 4-cycle output stall in the middle.
    sent = 0;
    a = 16'($urandom); b = 16'($urandom); c_in = 1'($urandom); sub = 1'($urandom);
    for (int cyc = 0; cyc < 40 && (sent < 8 || sb.size() > 0); cyc++) begin
      out_ready = !(cyc >= 5 && cyc < 9);
      in_valid  = (sent < 8);
      @(negedge clk);
      if (cyc >= 5 && cyc < 9) chk("stall_in_ready", 32'(in_ready), 32'd0);
      if (cyc >= 9 && sb.size() > 0) chk("no_gap_out_valid", 32'(out_valid), 32'd1);
      xfer = in_valid && in_ready;
      @(posedge clk); #1;
      if (xfer) begin
        sent++;
        a = 16'($urandom); b = 16'($urandom); c_in = 1'($urandom); sub = 1'($urandom);
      end
    end
    in_valid = 1'b0;
    chk("stream_sent", 32'(sent), 32'd8);
    chk("stream_drained", 32'(sb.size()), 32'd0);

    // Random valid/ready traffic.
    for (int cyc = 0; cyc < 300; cyc++) begin
      a = 16'($urandom); b = 16'($urandom); c_in = 1'($urandom); sub = 1'($urandom);
      if ((cyc % 50) == 7) begin a = 16'h5A5A; b = 16'hA5A5; sub = 1'b0; c_in = 1'b1; end
      in_valid  = ($urandom % 4) != 0;
      out_ready = ($urandom % 3) != 0;
      @(posedge clk); #1;
    end
    in_valid = 1'b0; out_ready = 1'b1;
    for (int i = 0; i < 20 && sb.size() > 0; i++) @(posedge clk);
    #1;
    chk("random_drained", 32'(sb.size()), 32'd0);

    // Asynchronous reset with three operations in flight.
    for (int i = 0; i < 3; i++) begin
      a = 16'($urandom) | 16'h0100; b = 16'h0001; c_in = 1'b0; sub = 1'b0; in_valid = 1'b1;
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    @(posedge clk); #1;
    chk("pre_rst_out_valid", 32'(out_valid), 32'd1);
    #1 rst = 1'b1;
    #1;
    chk("async_rst_out_valid", 32'(out_valid), 32'd0);
    chk("async_rst_s", 32'(s), 32'd0);
    chk("async_rst_in_ready", 32'(in_ready), 32'd1);
    @(posedge clk); @(posedge clk); #3 rst = 1'b0;
    @(posedge clk); #1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk("post_rst_no_stale", 32'(out_valid), 32'd0);
    end
    @(posedge clk); #1;
    run_one(16'h0001, 16'h0001, 1'b0, 1'b0, 16'h0002, 1'b0, 1'b0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

endmodule
